// File: rtl/spi_ram_ctrl.sv
// Byte-wide RAM behind the SPI slave: decodes 10-bit words into address/data commands.
// Optional SPI_RAM_AUTOINC_EN: post-increment the addresses after each data access.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StWaitRd, StTxHold} state_e;

    state_e                 state_q, state_d;
    logic                   rx_valid_q;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic                   wa_loaded_q, wa_loaded_d;
    logic                   ra_loaded_q, ra_loaded_d;
    logic [7:0]             dout_q, dout_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic                   accept;
    logic                   addr_ok;
    logic [7:0]             mem [MEM_DEPTH];

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction
`endif

    // Only the rising edge of rx_valid starts a command, however long it is held.
    assign accept  = rx_valid && !rx_valid_q;
    assign addr_ok = ({1'b0, din[7:0]} < 9'(MEM_DEPTH));

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wa_loaded_d = wa_loaded_q;
        ra_loaded_d = ra_loaded_q;
        dout_d      = dout_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        if (accept) begin
            if (state_q == StTxHold) begin
                state_d = StIdle;
            end
            case (din[9:8])
                2'b00: begin
                    if (addr_ok) begin
                        wr_addr_d   = din[ADDR_SIZE-1:0];
                        wa_loaded_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (wa_loaded_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        wr_addr_d = wrap_inc(wr_addr_q);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (addr_ok) begin
                        rd_addr_d   = din[ADDR_SIZE-1:0];
                        ra_loaded_d = 1'b1;
                        state_d     = StWaitRd;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (ra_loaded_q) begin
                        dout_d  = mem[rd_addr_q];
                        state_d = StTxHold;
`ifdef SPI_RAM_AUTOINC_EN
                        rd_addr_d = wrap_inc(rd_addr_q);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rx_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wa_loaded_q <= 1'b0;
            ra_loaded_q <= 1'b0;
            dout_q      <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_valid_q  <= rx_valid;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wa_loaded_q <= wa_loaded_d;
            ra_loaded_q <= ra_loaded_d;
            dout_q      <= dout_d;
            err_q       <= err_d;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign tx_valid = (state_q == StTxHold);
    assign dout     = dout_q;
    assign err      = err_q;

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Single-port byte-wide RAM with command decoder, sitting directly downstream of the SPI slave. It consumes the slave's 10-bit received words and executes the encoded operation: load write address, write data, load read address, or read data. It returns read bytes on the slave's transmit side through a `dout`/`tx_valid` pair. Each `rx_valid` assertion is processed exactly once, however many cycles it is held high.

## Interface
- `MEM_DEPTH`, 256, number of 8-bit words; legal range 2..256.
- `ADDR_SIZE`, 8, address register width; must satisfy 2^`ADDR_SIZE` >= `MEM_DEPTH` and `ADDR_SIZE` <= 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  10  received word; `[9:8]` command, `[7:0]` payload.
- `rx_valid`  in  1  `din` valid; level, may stay high for several cycles.
- `dout`  out  8  read data returned to the SPI slave.
- `tx_valid`  out  1  `dout` valid; held high (sticky) until the next accepted command.
- `err`  out  1  one-cycle pulse flagging a rejected command.

## Operation
- Edge detect:
  - Register `rx_valid_d`.
  - A command is accepted on the cycle where `rx_valid && !rx_valid_d`.
  - Only then is `din` decoded; all other cycles are no-ops.
- Internal state:
  - `wr_addr[ADDR_SIZE-1:0]`, `rd_addr[ADDR_SIZE-1:0]`.
  - Flags `wa_loaded`, `ra_loaded`.
  - `mem[0:MEM_DEPTH-1]`, which is not reset.
- Command `din[9:8]`:
  - 2'b00 WR_ADDR: if `din[7:0]` < `MEM_DEPTH`, set `wr_addr <= din[ADDR_SIZE-1:0]` and `wa_loaded <= 1`. Otherwise pulse `err`; `wr_addr` and `wa_loaded` are unchanged.
  - 2'b01 WR_DATA: if `wa_loaded`, set `mem[wr_addr] <= din[7:0]`. Otherwise pulse `err` and perform no write.
  - 2'b10 RD_ADDR: same as WR_ADDR but targets `rd_addr`/`ra_loaded`.
  - 2'b11 RD_DATA: if `ra_loaded`, set `dout <= mem[rd_addr]` and `tx_valid <= 1`. Otherwise pulse `err`; `dout` is unchanged and `tx_valid` stays 0.
- `tx_valid` clear: on any accepted command other than a successful RD_DATA, `tx_valid <= 0` on that edge. `dout` holds its last value.
- Controller FSM (2 bits):
  - IDLE -> WAIT_RD on a successful RD_ADDR.
  - WAIT_RD -> TX_HOLD on a successful RD_DATA.
  - TX_HOLD -> IDLE on the next accepted command, which is then processed normally (a RD_ADDR in TX_HOLD goes to WAIT_RD).
  - Writes do not change state.
  - `tx_valid == (state == TX_HOLD)` at all times.
- Simultaneous events: only one command can be accepted per cycle; there are no other concurrent sources.

## Timing
- Reset values (asynchronous):
  - Outputs: `dout` = 8'h00, `tx_valid` = 0, `err` = 0.
  - Internal: `wr_addr` = `rd_addr` = 0, flags = 0, `rx_valid_d` = 0, state IDLE.
- Write: memory is updated on the accepting edge; a RD_DATA accepted in a later cycle returns the new value.
- Read latency: `dout`/`tx_valid` are valid 1 cycle after the accepting edge (registered outputs).
- `err`: high for exactly the cycle after the accepting edge.
- Held `rx_valid`: a level held for N cycles yields 1 command. The next command needs `rx_valid` low for at least 1 cycle.
- Reset mid-operation: all registers return to reset values immediately. Memory contents are preserved. An in-flight `tx_valid` drops asynchronously.
- Address wrap (see Configuration): increment is modulo `MEM_DEPTH`; `MEM_DEPTH-1` + 1 -> 0.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After each successful WR_DATA, `wr_addr` increments modulo `MEM_DEPTH`.
  - After each successful RD_DATA, `rd_addr` increments modulo `MEM_DEPTH`.
  - Increments occur on the same accepting edge as the access.
- Undefined: addresses change only via WR_ADDR/RD_ADDR; repeated data commands hit the same location.

## Test plan
- Reset, then RD_DATA 10'h3_00 with no RD_ADDR -> `err` 1-cycle pulse, `tx_valid` stays 0, `dout` = 8'h00.
- WR_ADDR 10'h0_12, WR_DATA 10'h1_A5, RD_ADDR 10'h2_12, RD_DATA 10'h3_00 -> one cycle after the last accept, `dout` = 8'hA5 and `tx_valid` = 1; `tx_valid` holds until the next command, then drops with `dout` still 8'hA5.
- WR_DATA 10'h1_A5 with `rx_valid` held 5 cycles, after WR_ADDR 10'h0_07 -> exactly one write. Build with `SPI_RAM_AUTOINC_EN`: a readback via RD_ADDR 10'h2_08 returns the old contents of address 8 (not 8'hA5), confirming a single increment.
- `MEM_DEPTH` = 16: WR_ADDR 10'h0_10 -> `err` pulse and `wr_addr` unchanged. With `SPI_RAM_AUTOINC_EN`, WR_ADDR 10'h0_0F then two WR_DATA (8'h11, 8'h22) -> `mem[15]` = 8'h11, `mem[0]` = 8'h22.
- Assert `rst_n` low while in TX_HOLD -> `tx_valid` drops immediately. After reset, RD_ADDR to a previously written location, then RD_DATA -> pre-reset data is returned.
